key_expander_multi: RTL

KEY_EXPANDER_MULTI -- requirements
Module: key_expander_multi

---
 rtl/key_expander_multi.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/key_expander_multi.sv
// AES-128/256 key schedule generator: one round key per cycle, streamed out and
// stored in a 15-entry table readable at random with a one-cycle registered read.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] y;
        logic [7:0] r;
        y = gmul(a, a);
        r = y;
        for (int i = 0; i < 6; i++) begin
            y = gmul(y, y);
            r = gmul(r, y);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv   = ginv(in_i);
        out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module key_expander_multi #(
    parameter int BLOCK_LENGTH = 128,
    parameter int KEY_WIDTH    = 256,
    parameter bit ENABLE_256   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    key_mode,
    input  logic [KEY_WIDTH-1:0]    key_in,
    output logic                    busy,
    output logic                    done,
    output logic                    keys_valid,
    output logic                    rk_valid,
    output logic [3:0]              rk_idx,
    output logic [BLOCK_LENGTH-1:0] rk_data,
    input  logic [3:0]              rd_idx,
    output logic [BLOCK_LENGTH-1:0] rd_key,
    output logic                    rd_err
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t                    state_q;
    logic                      busy_q, done_q, kv_q, rkv_q, rd_err_q, mode_q;
    logic [3:0]                r_q, rk_idx_q;
    logic [BLOCK_LENGTH-1:0]   rk_data_q, rd_key_q;
    logic [2*BLOCK_LENGTH-1:0] win_q;
    logic [14:0]               valid_q;
    logic [BLOCK_LENGTH-1:0]   mem_q [15];

    logic                    accept, acc_mode, mode_d, odd, rd_err_d, wr_en;
    logic [3:0]              nr, nr_d, wr_idx, rc_idx;
    logic [14:0]             valid_d;
    logic [127:0]            base, new_rk;
    logic [BLOCK_LENGTH-1:0] wr_data, rd_key_d;
    logic [31:0]             w_last, sub_in, sub_out, temp, n0, n1, n2, n3;
    logic [7:0]              rc;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
            4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
            4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
            4'd10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.in_i(sub_in[8*b +: 8]), .out_o(sub_out[8*b +: 8]));
    end

    always_comb begin
        accept   = (state_q == IDLE) && start;
        acc_mode = ENABLE_256 && key_mode;
        nr       = mode_q ? 4'd14 : 4'd10;
        // AES-128 steps from the newest key; AES-256 XORs against the key two rounds back.
        base     = mode_q ? win_q[255:128] : win_q[127:0];
        w_last   = win_q[31:0];
        odd      = mode_q && r_q[0];
        sub_in   = odd ? w_last : {w_last[23:0], w_last[31:24]};
        rc_idx   = mode_q ? (r_q >> 1) : r_q;
        rc       = rcon(rc_idx);
        temp     = sub_out ^ (odd ? 32'h0 : {rc, 24'h0});
        n0       = base[127:96] ^ temp;
        n1       = base[95:64]  ^ n0;
        n2       = base[63:32]  ^ n1;
        n3       = base[31:0]   ^ n2;
        new_rk   = {n0, n1, n2, n3};

        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (accept) begin
            wr_en   = 1'b1;
            wr_data = key_in[KEY_WIDTH-1 -: BLOCK_LENGTH];
        end else if (state_q == EXPAND) begin
            wr_en   = 1'b1;
            wr_idx  = r_q;
            wr_data = (mode_q && r_q == 4'd1) ? win_q[127:0] : new_rk;
        end

        mode_d  = accept ? acc_mode : mode_q;
        nr_d    = mode_d ? 4'd14 : 4'd10;
        valid_d = accept ? 15'd1 : (valid_q | (wr_en ? (15'd1 << wr_idx) : 15'd0));
        // Reads see this cycle's write so a read chasing the stream never lags.
        rd_err_d = (rd_idx > nr_d) || !valid_d[rd_idx];
        rd_key_d = rd_err_d ? '0 :
                   ((wr_en && wr_idx == rd_idx) ? wr_data : mem_q[rd_idx]);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            kv_q      <= 1'b0;
            rkv_q     <= 1'b0;
            rk_idx_q  <= '0;
            rk_data_q <= '0;
            rd_key_q  <= '0;
            rd_err_q  <= 1'b0;
            valid_q   <= '0;
            win_q     <= '0;
            mode_q    <= 1'b0;
            r_q       <= '0;
        end else begin
            done_q   <= 1'b0;
            rkv_q    <= wr_en;
            valid_q  <= valid_d;
            mode_q   <= mode_d;
            rd_key_q <= rd_key_d;
            rd_err_q <= rd_err_d;
            if (wr_en) begin
                rk_idx_q  <= wr_idx;
                rk_data_q <= wr_data;
            end
            case (state_q)
                IDLE: if (start) begin
                    state_q <= EXPAND;
                    busy_q  <= 1'b1;
                    kv_q    <= 1'b0;
                    r_q     <= 4'd1;
                    win_q   <= {key_in[255:128], acc_mode ? key_in[127:0] : key_in[255:128]};
                end
                EXPAND: begin
                    // AES-256 round 1 is the raw second key half; the window already holds it.
                    if (!(mode_q && r_q == 4'd1)) win_q <= {win_q[127:0], new_rk};
                    if (r_q == nr) state_q <= DONE;
                    else           r_q     <= r_q + 4'd1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    kv_q    <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = kv_q;
    assign rk_valid   = rkv_q;
    assign rk_idx     = rk_idx_q;
    assign rk_data    = rk_data_q;
    assign rd_key     = rd_key_q;
    assign rd_err     = rd_err_q;
endmodule
